// File: rtl/button_conditioner_if.sv
// Button event bus: raw board levels in, conditioned levels and pulses out.
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic             btn_any;

  // Driver of raw levels / consumer of events (board or bench side).
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat, btn_any
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat, btn_any
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce FSM, press/release/repeat
// pulse generation per channel. Channels are independent lanes.

// One button channel.
module button_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_p,
  output logic repeat_p
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RELEASED, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  logic [1:0]    sync_q;
  logic          sync;
  state_t        st_q, st_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          first_q, first_d;
  logic          level_d, press_d, rel_d, rpt_d;

  assign sync = sync_q[1];

  // Two-flop synchroniser on the raw pad level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], raw};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= RELEASED;
      deb_q     <= '0;
      rep_q     <= '0;
      first_q   <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      st_q      <= st_d;
      deb_q     <= deb_d;
      rep_q     <= rep_d;
      first_q   <= first_d;
      level     <= level_d;
      press     <= press_d;
      release_p <= rel_d;
      repeat_p  <= rpt_d;
    end
  end

  // Debounce / repeat next-state logic; pulses default low so they last one cycle.
  always_comb begin
    st_d    = st_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    first_d = first_q;
    level_d = level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    case (st_q)
      RELEASED: begin
        if (sync) begin
          st_d  = DEB_PRESS;
          deb_d = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!sync) begin
          st_d  = RELEASED;
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          st_d    = HELD;
          deb_d   = '0;
          press_d = 1'b1;
          rpt_d   = 1'b1;
          level_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          // rep_cnt is kept so a release glitch does not restart repeat timing.
          st_d  = DEB_RELEASE;
          deb_d = DEB_ONE;
        end else if (REPEAT_EN) begin
          if (rep_q == (first_q ? DELAY_LAST : RATE_LAST)) begin
            rpt_d   = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + REP_ONE;
          end
        end
      end
      DEB_RELEASE: begin
        if (sync) begin
          st_d  = HELD;
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          st_d    = RELEASED;
          deb_d   = '0;
          rep_d   = '0;
          first_d = 1'b0;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      default: st_d = RELEASED;
    endcase
  end
endmodule

// Top: one lane per button, bit order {C,U,D,L,R} = [4:0].
module button_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 50000000,
  parameter int               REPEAT_RATE     = 15000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
  input logic                  clk,
  input logic                  rst,
  button_conditioner_if.slave  bus
);
  logic [N_BTN-1:0] level, press, rel, rpt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .raw       (bus.btn_raw[i]),
      .level     (level[i]),
      .press     (press[i]),
      .release_p (rel[i]),
      .repeat_p  (rpt[i])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_repeat  = rpt;
  assign bus.btn_any     = |level;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, DELAY=20, RATE=8).
module tb_button_conditioner;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_conditioner_if #(.N_BTN(N)) bus();

  button_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (8),
    .REPEAT_MASK     (5'b01111)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; returns at the negedge after the n-th rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] acc;
    logic         lvl_ok;
    int nrep, nprs, nrel, prs_t, rel_t;
    int rep_t [8];
    int exp_rep [6] = '{6, 26, 34, 42, 50, 58};

    bus.btn_raw = '0;
    step(2);
    chk("rst_level",   32'(bus.btn_level),   0);
    chk("rst_press",   32'(bus.btn_press),   0);
    chk("rst_release", 32'(bus.btn_release), 0);
    chk("rst_repeat",  32'(bus.btn_repeat),  0);
    chk("rst_any",     32'(bus.btn_any),     0);
    rst = 1'b1;
    step(3);

    // Clean press on ch3, press lands on edge 6; then release, pulse 6 edges later.
    bus.btn_raw = 5'b01000;
    step(5);
    chk("cp_press_early", 32'(bus.btn_press), 0);
    step(1);
    chk("cp_press",  32'(bus.btn_press),  32'h08);
    chk("cp_repeat", 32'(bus.btn_repeat), 32'h08);
    chk("cp_level",  32'(bus.btn_level),  32'h08);
    chk("cp_any",    32'(bus.btn_any),    1);
    step(1);
    chk("cp_press_off",  32'(bus.btn_press),  0);
    chk("cp_repeat_off", 32'(bus.btn_repeat), 0);
    chk("cp_level_hold", 32'(bus.btn_level),  32'h08);
    bus.btn_raw = '0;
    step(5);
    chk("cr_rel_early", 32'(bus.btn_release), 0);
    chk("cr_lvl_early", 32'(bus.btn_level),   32'h08);
    step(1);
    chk("cr_release", 32'(bus.btn_release), 32'h08);
    chk("cr_level",   32'(bus.btn_level),   0);
    step(1);
    chk("cr_rel_off", 32'(bus.btn_release), 0);
    step(4);

    // 3-cycle glitch on ch1 must be rejected.
    acc = '0;
    bus.btn_raw = 5'b00010;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      acc |= bus.btn_press | bus.btn_level;
      if (k == 3) bus.btn_raw = '0;
    end
    chk("bounce_press", 32'(acc), 0);

    // Hold ch1, then a 3-cycle release glitch: no release, level stays.
    bus.btn_raw = 5'b00010;
    step(8);
    chk("gl_level", 32'(bus.btn_level), 32'h02);
    acc = '0;
    lvl_ok = 1'b1;
    bus.btn_raw = '0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      acc |= bus.btn_release;
      lvl_ok &= bus.btn_level[1];
      if (k == 3) bus.btn_raw = 5'b00010;
    end
    chk("gl_release", 32'(acc), 0);
    chk("gl_lvl_kept", 32'(lvl_ok), 1);
    nrel = 0;
    bus.btn_raw = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (bus.btn_release[1]) nrel++;
    end
    chk("gl_final_rel", 32'(nrel), 1);
    chk("gl_final_lvl", 32'(bus.btn_level), 0);

    // Auto-repeat on ch2: t = index of rising edge since first sample of 1.
    nrep = 0; prs_t = -1; rel_t = -1;
    foreach (rep_t[i]) rep_t[i] = -1;
    bus.btn_raw = 5'b00100;
    for (int t = 1; t <= 80; t++) begin
      step(1);
      if (bus.btn_press[2]) prs_t = t;
      if (bus.btn_repeat[2]) begin
        if (nrep < 8) rep_t[nrep] = t;
        nrep++;
      end
      if (bus.btn_release[2]) rel_t = t;
      if (t == 60) bus.btn_raw = '0;
    end
    chk("ar_press_t", 32'(prs_t), 6);
    chk("ar_nrep", 32'(nrep), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("ar_rep%0d_t", i), 32'(rep_t[i]), 32'(exp_rep[i]));
    chk("ar_release_t", 32'(rel_t), 66);

    // C is masked: only the press-coincident repeat.
    nrep = 0; nprs = 0;
    bus.btn_raw = 5'b10000;
    for (int t = 1; t <= 70; t++) begin
      step(1);
      if (bus.btn_repeat[4]) nrep++;
      if (bus.btn_press[4]) nprs++;
    end
    chk("mk_nrep", 32'(nrep), 1);
    chk("mk_npress", 32'(nprs), 1);
    bus.btn_raw = '0;
    step(10);
    chk("mk_level", 32'(bus.btn_level), 0);

    // Simultaneous press on ch4 and ch0.
    bus.btn_raw = 5'b10001;
    step(5);
    chk("sim_early", 32'(bus.btn_press), 0);
    step(1);
    chk("sim_press",  32'(bus.btn_press),  32'h11);
    chk("sim_repeat", 32'(bus.btn_repeat), 32'h11);
    chk("sim_any",    32'(bus.btn_any),    1);
    step(1);
    chk("sim_off", 32'(bus.btn_press), 0);
    bus.btn_raw = '0;
    step(10);
    chk("sim_rel_lvl", 32'(bus.btn_level), 0);

    // Reset while ch2 held: async clear, then fresh press after reset.
    bus.btn_raw = 5'b00100;
    step(8);
    chk("mr_level_pre", 32'(bus.btn_level), 32'h04);
    #2 rst = 1'b0;
    #1;
    chk("mr_level",   32'(bus.btn_level),   0);
    chk("mr_press",   32'(bus.btn_press),   0);
    chk("mr_release", 32'(bus.btn_release), 0);
    chk("mr_repeat",  32'(bus.btn_repeat),  0);
    chk("mr_any",     32'(bus.btn_any),     0);
    @(negedge clk);
    rst = 1'b1;
    step(5);
    chk("mr_press_early", 32'(bus.btn_press), 0);
    step(1);
    chk("mr_press_after", 32'(bus.btn_press), 32'h04);
    chk("mr_level_after", 32'(bus.btn_level), 32'h04);
    bus.btn_raw = '0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
